// File: rtl/perf_pkg.sv
// Shared types and defaults for the pipeline performance monitor.
package perf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned SEL_CYCLE = 0;

  localparam int unsigned DEF_NUM_EVT     = 4;
  localparam int unsigned DEF_CNT_W       = 32;
  localparam int unsigned DEF_PC_W        = 32;
  localparam int unsigned DEF_TRACE_DEPTH = 16;

endpackage

// File: rtl/perf_trace_fifo.sv
// Synchronous trace FIFO; pointers carry a wrap bit so full and empty are told apart.
module perf_trace_fifo #(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign empty_o = (r_wptr == r_rptr);
  assign full_o  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  // A pop frees the head slot on the same edge, so a full FIFO can still accept.
  assign w_do_pop  = pop_i & ~empty_o;
  assign w_do_push = push_i & (~full_o | w_do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/pipeline_perf_monitor.sv
// Cycle/event counters with a run limit, registered readback and a {PC, events} trace FIFO.
module pipeline_perf_monitor
  import perf_pkg::*;
#(
  parameter int unsigned NUM_EVT     = DEF_NUM_EVT,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned PC_W        = DEF_PC_W,
  parameter int unsigned TRACE_DEPTH = DEF_TRACE_DEPTH
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             start_i,
  input  logic                             clear_i,
  input  logic [CNT_W-1:0]                 limit_i,
  input  logic [NUM_EVT-1:0]               evt_i,
  input  logic [PC_W-1:0]                  pc_i,
  input  logic [$clog2(NUM_EVT+2)-1:0]     rd_sel_i,
  output logic [CNT_W-1:0]                 rd_data_o,
  output logic                             running_o,
  output logic                             done_o,
  output logic [NUM_EVT:0]                 sat_o,
  output logic                             ovf_o,
  output logic                             trace_valid_o,
  input  logic                             trace_ready_i,
  output logic [PC_W-1:0]                  trace_pc_o,
  output logic [NUM_EVT-1:0]               trace_evt_o
);

  localparam int unsigned NCNT  = NUM_EVT + 1;
  localparam int unsigned SEL_W = $clog2(NUM_EVT + 2);
  localparam int unsigned REC_W = PC_W + NUM_EVT;

  state_e                      r_state;
  state_e                      w_state_next;
  logic                        w_clr;
  logic                        w_run;
  logic [NCNT-1:0]             w_inc;
  logic [NCNT-1:0][CNT_W-1:0]  w_cnt;
  logic [NCNT-1:0][CNT_W-1:0]  w_cnt_next;
  logic [NCNT-1:0]             w_sat;
  logic [CNT_W-1:0]            w_rd_sel;
  logic [CNT_W-1:0]            r_rd_data;
  logic                        r_ovf;
  logic                        w_push;
  logic                        w_drop;
  logic                        w_full;
  logic                        w_empty;
  logic [REC_W-1:0]            w_rdata;

  assign w_clr = rst_i | clear_i;
  assign w_run = (r_state == ST_RUN);
  assign w_inc = {evt_i, 1'b1};

  // Counter 0 is the cycle counter; counter k+1 follows event channel k.
  for (genvar k = 0; k < NCNT; k++) begin : g_cnt
    logic [CNT_W-1:0] r_cnt;
    logic             r_sat;
    logic             w_at_max;
    logic             w_hit;

    assign w_at_max      = &r_cnt;
    assign w_hit         = w_run & w_inc[k];
    assign w_cnt_next[k] = (w_hit && !w_at_max) ? r_cnt + 1'b1 : r_cnt;

    always_ff @(posedge clk_i) begin
      if (w_clr) begin
        r_cnt <= '0;
        r_sat <= 1'b0;
      end else begin
        r_cnt <= w_cnt_next[k];
        if (w_hit && w_at_max) r_sat <= 1'b1;
      end
    end

    assign w_cnt[k] = r_cnt;
    assign w_sat[k] = r_sat;
  end

  // DONE is taken on the edge that brings the cycle count to the limit.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: if (start_i) w_state_next = ST_RUN;
      ST_RUN: begin
        if ((limit_i != '0) && (w_cnt_next[SEL_CYCLE] == limit_i)) w_state_next = ST_DONE;
      end
      ST_DONE: w_state_next = ST_DONE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (w_clr) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_rd_sel = '0;
    for (int unsigned k = 0; k < NCNT; k++) begin
      if (rd_sel_i == SEL_W'(k)) w_rd_sel = w_cnt[k];
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_clr) r_rd_data <= '0;
    else       r_rd_data <= w_rd_sel;
  end

  assign w_push = w_run & (|evt_i);
  // Full implies non-empty, so a ready consumer always frees a slot this edge.
  assign w_drop = w_push & w_full & ~trace_ready_i;

  always_ff @(posedge clk_i) begin
    if (w_clr)       r_ovf <= 1'b0;
    else if (w_drop) r_ovf <= 1'b1;
  end

  perf_trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (TRACE_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (clear_i),
    .push_i  (w_push),
    .wdata_i ({pc_i, evt_i}),
    .pop_i   (trace_ready_i),
    .rdata_o (w_rdata),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign rd_data_o     = r_rd_data;
  assign running_o     = (r_state == ST_RUN);
  assign done_o        = (r_state == ST_DONE);
  assign sat_o         = w_sat;
  assign ovf_o         = r_ovf;
  assign trace_valid_o = ~w_empty;
  assign {trace_pc_o, trace_evt_o} = w_empty ? '0 : w_rdata;

endmodule

// File: tb/tb_pipeline_perf_monitor.sv
// Two monitor instances (32-bit/16-deep and 4-bit/4-deep) on shared stimulus, scoreboarded.
module tb_pipeline_perf_monitor;

  logic        clk = 1'b0;
  logic        rst, start, clear, ready;
  logic [31:0] limit, pc;
  logic [3:0]  lim_s, evt;
  logic [2:0]  rd_sel;

  logic [31:0] rd_b, tpc_b, tpc_s;
  logic [3:0]  rd_s, tevt_b, tevt_s;
  logic [4:0]  sat_b, sat_s;
  logic        run_b, done_b, ovf_b, tv_b;
  logic        run_s, done_s, ovf_s, tv_s;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  pipeline_perf_monitor #(
    .NUM_EVT(4), .CNT_W(32), .PC_W(32), .TRACE_DEPTH(16)
  ) u_big (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .limit_i(limit),
    .evt_i(evt), .pc_i(pc), .rd_sel_i(rd_sel), .rd_data_o(rd_b), .running_o(run_b),
    .done_o(done_b), .sat_o(sat_b), .ovf_o(ovf_b), .trace_valid_o(tv_b),
    .trace_ready_i(ready), .trace_pc_o(tpc_b), .trace_evt_o(tevt_b)
  );

  pipeline_perf_monitor #(
    .NUM_EVT(4), .CNT_W(4), .PC_W(32), .TRACE_DEPTH(4)
  ) u_small (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .limit_i(lim_s),
    .evt_i(evt), .pc_i(pc), .rd_sel_i(rd_sel), .rd_data_o(rd_s), .running_o(run_s),
    .done_o(done_s), .sat_o(sat_s), .ovf_o(ovf_s), .trace_valid_o(tv_s),
    .trace_ready_i(ready), .trace_pc_o(tpc_s), .trace_evt_o(tevt_s)
  );

  // Reference model: per instance, counts as plain integers clamped at the counter maximum,
  // a run/done flag pair, and the trace FIFO as a queue of expected records plus occupancy.
  longint      m_cnt [2][5];
  bit          m_sat [2][5];
  bit          m_run [2];
  bit          m_done[2];
  bit          m_ovf [2];
  int          m_occ [2];
  longint      m_rd  [2];
  bit          m_rd_ok[2];
  logic [35:0] q0[$];
  logic [35:0] q1[$];

  function automatic longint cnt_max(input int i);
    return (i == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hF;
  endfunction

  function automatic int depth(input int i);
    return (i == 0) ? 16 : 4;
  endfunction

  task automatic check(input string name, input int i, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s inst%0d got %0h expected %0h at %0t", name, i, got, exp, $time);
    end
  endtask

  task automatic model_reset(input int i);
    for (int k = 0; k < 5; k++) begin
      m_cnt[i][k] = 0;
      m_sat[i][k] = 1'b0;
    end
    m_run[i]  = 1'b0;
    m_done[i] = 1'b0;
    m_ovf[i]  = 1'b0;
    m_occ[i]  = 0;
    m_rd[i]   = 0;
    if (i == 0) q0.delete();
    else        q1.delete();
  endtask

  task automatic model_step(input int i);
    longint lim;
    bit     pop, push;
    lim = (i == 0) ? longint'(limit) : longint'(lim_s);
    if (rst) begin
      model_reset(i);
      m_rd_ok[i] = 1'b1;
      return;
    end
    if (clear) begin
      model_reset(i);
      m_rd_ok[i] = 1'b0;
      return;
    end
    m_rd[i]    = (rd_sel <= 3'd4) ? m_cnt[i][rd_sel] : 0;
    m_rd_ok[i] = 1'b1;
    pop  = (m_occ[i] > 0) && ready;
    push = m_run[i] && (evt != 4'd0);
    if (push && (m_occ[i] < depth(i) || pop)) begin
      if (i == 0) q0.push_back({pc, evt});
      else        q1.push_back({pc, evt});
      m_occ[i]++;
    end else if (push) begin
      m_ovf[i] = 1'b1;
    end
    if (pop) m_occ[i]--;
    if (m_run[i]) begin
      for (int k = 0; k < 5; k++) begin
        if (k == 0 || evt[k-1]) begin
          if (m_cnt[i][k] == cnt_max(i)) m_sat[i][k] = 1'b1;
          else                           m_cnt[i][k]++;
        end
      end
      if (lim != 0 && m_cnt[i][0] == lim) begin
        m_run[i]  = 1'b0;
        m_done[i] = 1'b1;
      end
    end else if (!m_done[i] && start) begin
      m_run[i] = 1'b1;
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic check_inst(input int i, input logic [31:0] rd, input logic run,
                            input logic done, input logic [4:0] sat, input logic ovf,
                            input logic tv, input logic [31:0] tpc, input logic [3:0] tevt);
    logic [4:0]  es;
    logic [35:0] exp_rec;
    for (int k = 0; k < 5; k++) es[k] = m_sat[i][k];
    check("running", i, 64'(run), 64'(m_run[i]));
    check("done", i, 64'(done), 64'(m_done[i]));
    check("sat", i, 64'(sat), 64'(es));
    check("ovf", i, 64'(ovf), 64'(m_ovf[i]));
    check("trace_valid", i, 64'(tv), 64'(m_occ[i] > 0));
    if (m_rd_ok[i]) check("rd_data", i, 64'(rd), 64'(m_rd[i]));
    if (tv && ready) begin
      if ((i == 0 ? q0.size() : q1.size()) == 0) begin
        check("trace_extra", i, 64'({tpc, tevt}), 64'hDEAD_0000_0000);
      end else begin
        exp_rec = (i == 0) ? q0.pop_front() : q1.pop_front();
        check("trace_rec", i, 64'({tpc, tevt}), 64'(exp_rec));
      end
    end else if (!tv) begin
      check("trace_idle", i, 64'({tpc, tevt}), 64'd0);
    end
  endtask

  // Handshakes are judged at the falling edge, ahead of the rising edge that performs them.
  always @(negedge clk) begin
    if (chk_en) begin
      check_inst(0, rd_b, run_b, done_b, sat_b, ovf_b, tv_b, tpc_b, tevt_b);
      check_inst(1, {28'd0, rd_s}, run_s, done_s, sat_s, ovf_s, tv_s, tpc_s, tevt_s);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; clear = 1'b0; ready = 1'b0;
    limit = 32'd0; lim_s = 4'd0; evt = 4'd0; pc = 32'd0; rd_sel = 3'd0;
    tick();
    tick();
    rst = 1'b0;
    chk_en = 1'b1;
    tick();

    // Cycle limit of 30: stops exactly at 30 and stays there.
    limit = 32'd30; start = 1'b1; ready = 1'b1;
    repeat (40) tick();
    check("limit_cycles", 0, 64'(rd_b), 64'd30);
    check("limit_done", 0, 64'(done_b), 64'd1);
    start = 1'b0;
    pulse_clear();
    tick();
    check("clear_idle", 0, 64'({run_b, done_b}), 64'd0);

    // Alternating channels 0/1 over 10 cycles, consumer stalled.
    limit = 32'd0; start = 1'b1; ready = 1'b0;
    tick();
    for (int c = 0; c < 10; c++) begin
      pc  = $urandom;
      evt = {2'b00, c[0], ~c[0]};
      tick();
    end
    evt = 4'd0; start = 1'b0; rd_sel = 3'd1;
    tick();
    tick();
    check("evt0_count", 0, 64'(rd_b), 64'd5);
    rd_sel = 3'd2;
    tick();
    tick();
    check("evt1_count", 0, 64'(rd_b), 64'd5);
    ready = 1'b1;
    repeat (12) tick();
    check("drained", 0, 64'(tv_b), 64'd0);
    pulse_clear();

    // Six events into a 4-deep FIFO with no consumer: overflow on the small instance.
    start = 1'b1; ready = 1'b0;
    tick();
    for (int c = 0; c < 6; c++) begin
      pc  = $urandom;
      evt = 4'(1 << (c % 4));
      tick();
    end
    evt = 4'd0;
    tick();
    check("ovf_small", 1, 64'(ovf_s), 64'd1);
    check("ovf_big", 0, 64'(ovf_b), 64'd0);
    ready = 1'b1;
    repeat (8) tick();
    pulse_clear();

    // Fill to full, then push and pop together: nothing dropped.
    start = 1'b1; ready = 1'b0;
    tick();
    for (int c = 0; c < 10; c++) begin
      if (c == 4) ready = 1'b1;
      pc  = $urandom;
      evt = 4'd8;
      tick();
    end
    evt = 4'd0;
    check("no_drop", 1, 64'(ovf_s), 64'd0);
    check("still_full", 1, 64'(tv_s), 64'd1);
    repeat (6) tick();
    pulse_clear();

    // Channel 2 for 20 cycles saturates the 4-bit counter.
    start = 1'b1;
    tick();
    for (int c = 0; c < 20; c++) begin
      pc  = $urandom;
      evt = 4'd4;
      tick();
    end
    evt = 4'd0; rd_sel = 3'd3;
    tick();
    tick();
    check("sat_count", 1, 64'(rd_s), 64'd15);
    check("sat_flag", 1, 64'(sat_s[3]), 64'd1);
    start = 1'b0;
    pulse_clear();
    tick();
    tick();
    check("clr_count", 1, 64'(rd_s), 64'd0);
    check("clr_sat", 1, 64'(sat_s), 64'd0);
    check("clr_state", 1, 64'({run_s, done_s}), 64'd0);

    // Randomised traffic, including occasional clears, resets and limit changes.
    for (int c = 0; c < 500; c++) begin
      if (c % 50 == 0) begin
        limit = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(5, 80));
        lim_s = 4'($urandom_range(0, 15));
      end
      rst    = ($urandom_range(0, 149) == 0);
      clear  = ($urandom_range(0, 59) == 0);
      start  = ($urandom_range(0, 3) != 0);
      evt    = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
      pc     = $urandom;
      ready  = ($urandom_range(0, 2) != 0);
      rd_sel = 3'($urandom_range(0, 7));
      tick();
    end
    rst = 1'b0; clear = 1'b0;

    // Reset mid-run with records queued.
    pulse_clear();
    limit = 32'd0; lim_s = 4'd0; start = 1'b1; ready = 1'b0; rd_sel = 3'd0;
    tick();
    for (int c = 0; c < 5; c++) begin
      pc  = $urandom;
      evt = 4'd1;
      tick();
    end
    evt = 4'd0; rst = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    check("rst_valid", 0, 64'(tv_b), 64'd0);
    check("rst_rd", 0, 64'(rd_b), 64'd0);
    check("rst_run", 0, 64'(run_b), 64'd0);
    check("rst_trace", 0, 64'({tpc_b, tevt_b}), 64'd0);
    repeat (3) tick();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
